membus_arbiter: RTL

//  Shares one MemBusReq/MemBusResp memory port between the instruction-side (I) and

---
 rtl/membus_arbiter_if.sv | 71 +++++++
 rtl/membus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter_if.sv
// ---------------------------------------------------------------------------
// membus_arbiter_if
//   Bundles the request/response signals around membus_arbiter:
//   the instruction-side (i_*) and data-side (d_*) requester ports plus the
//   shared downstream memory port (m_*).
//
//   Modports
//     slave  : arbiter view. Takes requests from I/D and returns responses.
//              Drives the downstream request and receives its response.
//     master : environment view (caches + memory), opposite directions.
//
//   Per requester x in {i, d}:
//     x_valid/x_addr/x_wen/x_wdata   request in
//     x_ready                        request accepted this cycle
//     x_rvalid/x_rerror/x_raddr/x_rdata  one-cycle response pulse
//   Downstream:
//     m_valid/m_addr/m_wen/m_wdata   registered request out
//     m_ready                        downstream accepts
//     m_rvalid/m_rerror/m_raddr/m_rdata  downstream response in
// ---------------------------------------------------------------------------
interface membus_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_wen;
    logic [31:0]       i_wdata;
    logic              i_rvalid;
    logic              i_rerror;
    logic [ADDR_W-1:0] i_raddr;
    logic [31:0]       i_rdata;

    logic              d_valid;
    logic              d_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wen;
    logic [31:0]       d_wdata;
    logic              d_rvalid;
    logic              d_rerror;
    logic [ADDR_W-1:0] d_raddr;
    logic [31:0]       d_rdata;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wen;
    logic [31:0]       m_wdata;
    logic              m_rvalid;
    logic              m_rerror;
    logic [ADDR_W-1:0] m_raddr;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_valid, i_addr, i_wen, i_wdata,
        output i_ready, i_rvalid, i_rerror, i_raddr, i_rdata,
        input  d_valid, d_addr, d_wen, d_wdata,
        output d_ready, d_rvalid, d_rerror, d_raddr, d_rdata,
        output m_valid, m_addr, m_wen, m_wdata,
        input  m_ready, m_rvalid, m_rerror, m_raddr, m_rdata
    );

    modport master (
        output i_valid, i_addr, i_wen, i_wdata,
        input  i_ready, i_rvalid, i_rerror, i_raddr, i_rdata,
        output d_valid, d_addr, d_wen, d_wdata,
        input  d_ready, d_rvalid, d_rerror, d_raddr, d_rdata,
        input  m_valid, m_addr, m_wen, m_wdata,
        output m_ready, m_rvalid, m_rerror, m_raddr, m_rdata
    );
endinterface

// File: rtl/membus_arbiter.sv
// ---------------------------------------------------------------------------
// membus_arbiter
//   Shares one memory port between the instruction-side (I) and data-side (D)
//   cache controllers. One transaction is in flight at a time: it is accepted
//   in IDLE, issued downstream from registers in ISSUE, and its single
//   response is routed back to the owner in WAIT.
//
//   Parameters
//     ADDR_W       address width
//     TIMEOUT_CYC  WAIT cycles before an error response is synthesised;
//                  0 disables the timeout
//     TO_CNT_W     timeout counter width (TIMEOUT_CYC < 2**TO_CNT_W)
//
//   Ports
//     clk    in  clock, everything on posedge
//     reset  in  synchronous, active-high
//     bus    membus_arbiter_if.slave: I/D request/response + downstream port
//
//   Build option
//     MEMBUS_ARB_ROUND_ROBIN_EN  defined: round robin on a tie (side not
//                                granted last wins).
//                                undefined: fixed priority, D over I.
// ---------------------------------------------------------------------------
module membus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned TO_CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    membus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam bit                  TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_EN ? TO_CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_t              state;
    owner_t              owner;
    logic                stale;     // a timed-out response is still owed by downstream
    logic [TO_CNT_W-1:0] to_cnt;
    logic                m_valid_q;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_wen;
    logic [31:0]         req_wdata;

`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
    owner_t              last_grant;
`endif

    // ------------------------------------------------------------------
    // Grant: combinational from the valids; only in IDLE with no stale
    // response pending. Reset masks it so nothing is accepted that cycle.
    // ------------------------------------------------------------------
    logic can_grant;
    logic tie_to_d;
    logic grant_i;
    logic grant_d;

    always_comb begin
        can_grant = (state == ST_IDLE) && !stale && !reset;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
        tie_to_d  = (last_grant == OWN_I);
`else
        tie_to_d  = 1'b1;
`endif
        grant_d   = can_grant && bus.d_valid && (!bus.i_valid || tie_to_d);
        grant_i   = can_grant && bus.i_valid && (!bus.d_valid || !tie_to_d);
    end

    // ------------------------------------------------------------------
    // Response: a real downstream response wins over a timeout landing in
    // the same cycle. Fields are forced to zero when nothing is signalled.
    // ------------------------------------------------------------------
    logic              in_wait;
    logic              resp_fire;
    logic              to_fire;
    logic              rsp_valid;
    logic              rsp_err;
    logic [ADDR_W-1:0] rsp_addr;
    logic [31:0]       rsp_data;

    always_comb begin
        in_wait   = (state == ST_WAIT) && !reset;
        resp_fire = in_wait && bus.m_rvalid;
        to_fire   = TO_EN && in_wait && !bus.m_rvalid && (to_cnt == TO_LAST);
        rsp_valid = resp_fire || to_fire;
        rsp_err   = 1'b0;
        rsp_addr  = '0;
        rsp_data  = '0;
        if (resp_fire) begin
            rsp_err  = bus.m_rerror;
            rsp_addr = bus.m_raddr;
            rsp_data = bus.m_rdata;
        end else if (to_fire) begin
            rsp_err  = 1'b1;
            rsp_addr = req_addr;
            rsp_data = '0;
        end
    end

    logic rsp_to_i;
    logic rsp_to_d;

    assign rsp_to_i = rsp_valid && (owner == OWN_I);
    assign rsp_to_d = rsp_valid && (owner == OWN_D);

    assign bus.i_ready  = grant_i;
    assign bus.d_ready  = grant_d;

    assign bus.i_rvalid = rsp_to_i;
    assign bus.i_rerror = rsp_to_i && rsp_err;
    assign bus.i_raddr  = rsp_to_i ? rsp_addr : '0;
    assign bus.i_rdata  = rsp_to_i ? rsp_data : '0;

    assign bus.d_rvalid = rsp_to_d;
    assign bus.d_rerror = rsp_to_d && rsp_err;
    assign bus.d_raddr  = rsp_to_d ? rsp_addr : '0;
    assign bus.d_rdata  = rsp_to_d ? rsp_data : '0;

    assign bus.m_valid  = m_valid_q;
    assign bus.m_addr   = req_addr;
    assign bus.m_wen    = req_wen;
    assign bus.m_wdata  = req_wdata;

    // ------------------------------------------------------------------
    // Control FSM with registered downstream request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_I;
            stale     <= 1'b0;
            to_cnt    <= '0;
            m_valid_q <= 1'b0;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
            last_grant <= OWN_I;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // The owed response after a timeout is swallowed here;
                    // grants stay blocked until it has arrived.
                    if (stale && bus.m_rvalid) begin
                        stale <= 1'b0;
                    end
                    if (grant_d) begin
                        owner     <= OWN_D;
                        req_addr  <= bus.d_addr;
                        req_wen   <= bus.d_wen;
                        req_wdata <= bus.d_wdata;
                        m_valid_q <= 1'b1;
                        state     <= ST_ISSUE;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
                        last_grant <= OWN_D;
`endif
                    end else if (grant_i) begin
                        owner     <= OWN_I;
                        req_addr  <= bus.i_addr;
                        req_wen   <= bus.i_wen;
                        req_wdata <= bus.i_wdata;
                        m_valid_q <= 1'b1;
                        state     <= ST_ISSUE;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
                        last_grant <= OWN_I;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        to_cnt    <= '0;
                        state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.m_rvalid) begin
                        state <= ST_IDLE;
                    end else if (to_fire) begin
                        stale <= 1'b1;
                        state <= ST_IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
